// File: rtl/param_cache_pkg.sv
// Shared types and default geometry for the parametrised L1 cache.
package cache_types;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    FILL
  } state_e;

  localparam int unsigned DEF_S_OFFSET = 5;
  localparam int unsigned DEF_S_INDEX  = 3;
  localparam int unsigned DEF_WAYS     = 4;

endpackage

// File: rtl/param_cache_plru_tree.sv
// Tree pseudo-LRU for one set: heap-ordered nodes, root at bit 0, a 0 bit points the victim to the lower half.
module plru_tree
  import cache_types::*;
#(
  parameter int unsigned WAYS = DEF_WAYS
) (
  input  logic [WAYS-2:0]         bits_i,
  input  logic [$clog2(WAYS)-1:0] way_i,
  output logic [WAYS-2:0]         bits_o,
  output logic [$clog2(WAYS)-1:0] victim_o
);

  localparam int unsigned LVL = $clog2(WAYS);

  always_comb begin
    int unsigned node;
    int unsigned vnode;
    logic        b;
    logic        vb;
    bits_o = bits_i;
    node   = 0;
    vnode  = 0;
    b      = 1'b0;
    vb     = 1'b0;
    for (int unsigned l = 0; l < LVL; l++) begin
      // walk the accessed way's path, pointing each node at the other half
      b = way_i[LVL-1-l];
      for (int unsigned n = 0; n < WAYS - 1; n++) begin
        if (n == node) bits_o[n] = ~b;
      end
      node = 2 * node + (b ? 2 : 1);
      vb = 1'b0;
      for (int unsigned n = 0; n < WAYS - 1; n++) begin
        if (n == vnode) vb = bits_i[n];
      end
      vnode = 2 * vnode + (vb ? 2 : 1);
    end
    victim_o = LVL'(vnode - (WAYS - 1));
  end

endmodule

// File: rtl/param_cache.sv
// N-way set-associative, write-back, write-allocate L1 cache with tree PLRU and hit/miss counters.
module param_cache
  import cache_types::*;
#(
  parameter int unsigned S_OFFSET = DEF_S_OFFSET,
  parameter int unsigned S_INDEX  = DEF_S_INDEX,
  parameter int unsigned WAYS     = DEF_WAYS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   mem_address,
  output logic [31:0]                   mem_rdata,
  input  logic [31:0]                   mem_wdata,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [3:0]                    mem_byte_enable,
  output logic                          mem_resp,
  output logic [31:0]                   pmem_address,
  input  logic [8*(2**S_OFFSET)-1:0]    pmem_rdata,
  output logic [8*(2**S_OFFSET)-1:0]    pmem_wdata,
  output logic                          pmem_read,
  output logic                          pmem_write,
  input  logic                          pmem_resp,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count
);

  localparam int unsigned LW    = 8 * (2 ** S_OFFSET);
  localparam int unsigned SETS  = 2 ** S_INDEX;
  localparam int unsigned TAGW  = 32 - S_INDEX - S_OFFSET;
  localparam int unsigned WAY_W = $clog2(WAYS);

  typedef logic [TAGW-1:0]  tag_t;
  typedef logic [LW-1:0]    line_t;
  typedef logic [WAY_W-1:0] way_t;
  typedef logic [WAYS-2:0]  plru_t;

  state_e          state_q, state_d;
  way_t            victim_q, victim_d;
  logic            refill_q, refill_d;
  logic [31:0]     hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  line_t           data_q [SETS][WAYS];
  line_t           data_d [SETS][WAYS];
  tag_t            tag_q  [SETS][WAYS];
  tag_t            tag_d  [SETS][WAYS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] valid_d [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WAYS-1:0] dirty_d [SETS];
  plru_t           plru_q [SETS];
  plru_t           plru_d [SETS];

  tag_t                 req_tag;
  logic [S_INDEX-1:0]   idx;
  logic [S_OFFSET-3:0]  wsel;
  logic                 req, hit, free_found, unused_addr_bits;
  way_t                 hit_way, free_way, plru_victim;
  plru_t                plru_upd;
  line_t                hit_line, merged;

  always_comb begin
    req_tag          = mem_address[31 -: TAGW];
    idx              = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
    wsel             = mem_address[S_OFFSET-1:2];
    req              = mem_read | mem_write;
    unused_addr_bits = ^mem_address[1:0];
  end

  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == req_tag && !hit) begin
        hit     = 1'b1;
        hit_way = way_t'(w);
      end
      if (!valid_q[idx][w] && !free_found) begin
        free_found = 1'b1;
        free_way   = way_t'(w);
      end
    end
  end

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits_i   (plru_q[idx]),
    .way_i    (hit_way),
    .bits_o   (plru_upd),
    .victim_o (plru_victim)
  );

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    refill_d     = refill_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    data_d       = data_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    plru_d       = plru_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    hit_line     = data_q[idx][hit_way];
    merged       = hit_line;
    for (int unsigned b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) merged[32*wsel + 8*b +: 8] = mem_wdata[8*b +: 8];
    end
    unique case (state_q)
      CHECK: begin
        refill_d = 1'b0;
        if (req && hit) begin
          mem_resp  = 1'b1;
          mem_rdata = hit_line[32*wsel +: 32];
          if (mem_write) begin
            data_d[idx][hit_way]  = merged;
            dirty_d[idx][hit_way] = 1'b1;
          end
          plru_d[idx] = plru_upd;
          // the hit that completes a refill was already counted as a miss
          if (!refill_q) hit_count_d = hit_count_q + 32'd1;
        end else if (req) begin
          victim_d     = free_found ? free_way : plru_victim;
          miss_count_d = miss_count_q + 32'd1;
          state_d      = (!free_found && dirty_q[idx][plru_victim]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx][victim_q], idx, {S_OFFSET{1'b0}}};
        pmem_wdata   = data_q[idx][victim_q];
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, idx, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          data_d[idx][victim_q]  = pmem_rdata;
          tag_d[idx][victim_q]   = req_tag;
          valid_d[idx][victim_q] = 1'b1;
          dirty_d[idx][victim_q] = 1'b0;
          refill_d               = 1'b1;
          state_d                = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
    hit_count  = hit_count_q;
    miss_count = miss_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CHECK;
      victim_q     <= '0;
      refill_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      refill_q     <= refill_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      plru_q       <= plru_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

endmodule
